mem_seq: RTL
============

MEM_SEQ -- requirements
Module: mem_seq

Interface
REQ-001 SHALL have parameter TIMEOUT, default 255: maximum wait cycles per byte before the access is aborted.
REQ-002 SHALL have port clk, input, 1: the only clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have port mem_op, input, 8, active-low one-hot {lb, lh, lw, lbu, lhu, sb, sh, sw}; 8'hFF means no access.
REQ-005 SHALL have port addr, input, 32: byte address from the ALU.
REQ-006 SHALL have port wdata, input, 32: store data (rs2).
REQ-007 SHALL have port rdata, output, 32: extended load result.
REQ-008 SHALL have port stall_n, output, 1, active low: holds the pipeline.
REQ-009 SHALL have port done_n, output, 1, active low: one-cycle completion pulse.
REQ-010 SHALL have port err_n, output, 1, active low: one-cycle pulse for a misaligned, illegal or timed-out access.
REQ-011 SHALL have port bus_addr, output, 32: byte address on the external 8-bit bus.
REQ-012 SHALL have port bus_wdata, output, 8: write byte.
REQ-013 SHALL have port bus_rdata, input, 8: read byte.
REQ-014 SHALL have port bus_oe_n, output, 1, active low: read strobe.
REQ-015 SHALL have port bus_we_n, output, 1, active low: write strobe.
REQ-016 SHALL have port bus_ready_n, input, 1, active low: byte cycle complete.

Function
REQ-017 SHALL implement states IDLE, ACCESS, GAP, DONE and ERR.
REQ-018 SHALL accept a request in IDLE when mem_op != 8'hFF, latching the op, addr and wdata, and clearing the byte index and timeout counter.
REQ-019 SHALL go from IDLE to ERR when mem_op has more than one bit low, when lh/lhu/sh has addr[0]=1, or when lw/sw has addr[1:0] != 0; no bus strobe SHALL assert in that case.
REQ-020 SHALL otherwise go from IDLE to ACCESS.
REQ-021 SHALL use byte counts of 1 for b/bu, 2 for h/hu and 4 for w.
REQ-022 SHALL drive, in ACCESS, bus_addr = latched addr + idx with no carry beyond bit 1, bus_oe_n low for loads or bus_we_n low for stores, and bus_wdata = wdata[8*idx+7 : 8*idx] (little-endian).
REQ-023 SHALL, in ACCESS, sample bus_ready_n at each edge; when it is low, store bus_rdata into byte idx of the load buffer, increment idx, and go to DONE if idx was the last byte, otherwise to GAP.
REQ-024 SHALL keep both strobes high in GAP and in every state other than ACCESS; GAP lasts exactly one cycle and then returns to ACCESS.
REQ-025 SHALL count ACCESS cycles while bus_ready_n is high; on reaching TIMEOUT it SHALL go to ERR, release the strobes and discard the partial data.
REQ-026 SHALL clear the timeout counter on every byte completion.
REQ-027 SHALL hold done_n low for exactly one cycle in DONE, then return to IDLE.
REQ-028 SHALL hold err_n low for exactly one cycle in ERR, then return to IDLE; rdata SHALL be unchanged on error.
REQ-029 SHALL update rdata on entry to DONE for loads only, and hold it until the next completed load.
REQ-030 SHALL sign-extend rdata from bit 7 for lb and bit 15 for lh, and zero-extend for lbu/lhu.
REQ-031 SHALL drive stall_n low combinationally when state != IDLE, or when in IDLE with mem_op != 8'hFF; stall_n SHALL be high in the DONE and ERR cycles so the pipeline advances.
REQ-032 SHALL ignore mem_op changes while not in IDLE.
REQ-033 SHALL meet a latency of 2N cycles from acceptance to done_n for N bytes with zero wait states (lw: done_n in cycle 8).

Reset
REQ-034 SHALL, while rst is low, asynchronously force state IDLE, rdata=0, stall_n=1, done_n=1, err_n=1, bus_oe_n=1, bus_we_n=1, bus_addr=0, bus_wdata=0, idx=0 and timeout counter=0.
REQ-035 SHALL, on reset mid-access, abort the access immediately with no done_n or err_n pulse.

Structure
REQ-036 SHALL place the state encoding, mem_op bit indices (LB=7 ... SW=0), byte-count constants and the TIMEOUT default in shared package mem_seq_pkg.
REQ-037 SHALL implement the per-byte wait counter as sub-module mem_seq_timeout (clear, count enable, expired flag).

Verification
REQ-038 SHALL test: lw at 0x100 with ready low every ACCESS cycle, bus bytes 78,56,34,12 -> rdata=0x12345678 and done_n low in cycle 8.
REQ-039 SHALL test: lb at 0x203 with bus byte 0x80 -> rdata=0xFFFFFF80; lbu with the same byte -> rdata=0x00000080.
REQ-040 SHALL test: sh at 0x10, wdata=0xAABBCCDD -> bus_we_n pulses at 0x10 with data DD and at 0x11 with data CC, then done_n.
REQ-041 SHALL test: lw at 0x102 -> err_n low in cycle 1, no strobes, rdata unchanged.
REQ-042 SHALL test: TIMEOUT=4 with bus_ready_n held high -> err_n after 4 ACCESS cycles, strobes released, state returns to IDLE.
REQ-043 SHALL test: rst low during byte 2 of lw -> strobes high at once, stall_n=1, and no done_n pulse.

Source files
------------

// File: rtl/mem_seq_pkg.sv
// Shared definitions for the byte-serial load/store sequencer: FSM encoding,
// active-low mem_op bit positions, byte counts and decode helpers.
package mem_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ACCESS = 3'd1,
        ST_GAP    = 3'd2,
        ST_DONE   = 3'd3,
        ST_ERR    = 3'd4
    } state_e;

    localparam int OP_LB  = 7;
    localparam int OP_LH  = 6;
    localparam int OP_LW  = 5;
    localparam int OP_LBU = 4;
    localparam int OP_LHU = 3;
    localparam int OP_SB  = 2;
    localparam int OP_SH  = 1;
    localparam int OP_SW  = 0;

    localparam logic [7:0] OP_NONE = 8'hFF;

    localparam logic [2:0] NB_BYTE = 3'd1;
    localparam logic [2:0] NB_HALF = 3'd2;
    localparam logic [2:0] NB_WORD = 3'd4;

    localparam int TIMEOUT_DEFAULT = 255;

    function automatic logic [2:0] op_nbytes(input logic [7:0] op);
        logic [2:0] n;
        if (!op[OP_LW] || !op[OP_SW]) begin
            n = NB_WORD;
        end else if (!op[OP_LH] || !op[OP_LHU] || !op[OP_SH]) begin
            n = NB_HALF;
        end else begin
            n = NB_BYTE;
        end
        return n;
    endfunction

    function automatic logic op_is_load(input logic [7:0] op);
        return op[OP_SB] && op[OP_SH] && op[OP_SW];
    endfunction

    // More than one low bit is detected by clearing the lowest set bit of ~op.
    function automatic logic op_illegal(input logic [7:0] op, input logic [1:0] a);
        logic [7:0] sel;
        logic       multi;
        logic       misal;
        sel   = ~op;
        multi = ((sel & (sel - 8'd1)) != 8'd0);
        misal = ((op_nbytes(op) == NB_HALF) && a[0]) ||
                ((op_nbytes(op) == NB_WORD) && (a != 2'd0));
        return multi || misal;
    endfunction

    function automatic logic [31:0] load_extend(input logic [7:0] op, input logic [31:0] raw);
        logic [31:0] r;
        if (!op[OP_LB]) begin
            r = {{24{raw[7]}}, raw[7:0]};
        end else if (!op[OP_LH]) begin
            r = {{16{raw[15]}}, raw[15:0]};
        end else if (!op[OP_LBU]) begin
            r = {24'd0, raw[7:0]};
        end else if (!op[OP_LHU]) begin
            r = {16'd0, raw[15:0]};
        end else begin
            r = raw;
        end
        return r;
    endfunction

endpackage

// File: rtl/mem_seq_timeout.sv
// Per-byte wait-state counter: counts enabled cycles and flags when the
// current wait cycle is the last one allowed.
module mem_seq_timeout
    import mem_seq_pkg::*;
#(
    parameter int LIMIT = TIMEOUT_DEFAULT
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0] cnt_r;

    // Wait-cycle counter, saturating at the last allowed value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r <= {CW{1'b0}};
        end else if (clr) begin
            cnt_r <= {CW{1'b0}};
        end else if (en && !expired) begin
            cnt_r <= cnt_r + CW'(32'd1);
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign expired = (cnt_r == LAST);

endmodule

// File: rtl/mem_seq.sv
// Sequences 8/16/32-bit loads and stores as little-endian byte cycles on an
// 8-bit handshake bus, with alignment checking and per-byte timeout.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  mem_op,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        stall_n,
    output logic        done_n,
    output logic        err_n,
    output logic [31:0] bus_addr,
    output logic [7:0]  bus_wdata,
    input  logic [7:0]  bus_rdata,
    output logic        bus_oe_n,
    output logic        bus_we_n,
    input  logic        bus_ready_n
);

    state_e      state_r, state_s;
    logic [7:0]  op_r, op_s;
    logic [31:0] addr_r, addr_s;
    logic [31:0] wdata_r, wdata_s;
    logic [31:0] ld_buf_r, ld_buf_s;
    logic [31:0] rdata_r, rdata_s;
    logic [1:0]  idx_r, idx_s;
    logic [31:0] bus_addr_r;
    logic [7:0]  bus_wdata_r;
    logic        bus_oe_n_r, bus_we_n_r, done_n_r, err_n_r;
    logic        tmo_clr_s, tmo_en_s, tmo_exp_s;
    logic        last_byte_s, busy_s;

    assign last_byte_s = ({1'b0, idx_r} == (op_nbytes(op_r) - 3'd1));

    mem_seq_timeout #(.LIMIT(TIMEOUT)) u_timeout (
        .clk     (clk),
        .rst_n   (rst),
        .clr     (tmo_clr_s),
        .en      (tmo_en_s),
        .expired (tmo_exp_s)
    );

    // Next-state, request latching and load-buffer assembly.
    always_comb begin
        state_s   = state_r;
        op_s      = op_r;
        addr_s    = addr_r;
        wdata_s   = wdata_r;
        idx_s     = idx_r;
        ld_buf_s  = ld_buf_r;
        rdata_s   = rdata_r;
        tmo_clr_s = 1'b0;
        tmo_en_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (mem_op != OP_NONE) begin
                    op_s      = mem_op;
                    addr_s    = addr;
                    wdata_s   = wdata;
                    idx_s     = 2'd0;
                    ld_buf_s  = 32'd0;
                    tmo_clr_s = 1'b1;
                    if (op_illegal(mem_op, addr[1:0])) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (!bus_ready_n) begin
                    ld_buf_s[{idx_r, 3'b000} +: 8] = bus_rdata;
                    idx_s     = idx_r + 2'd1;
                    tmo_clr_s = 1'b1;
                    if (last_byte_s) begin
                        state_s = ST_DONE;
                        if (op_is_load(op_r)) begin
                            rdata_s = load_extend(op_r, ld_buf_s);
                        end else begin
                            rdata_s = rdata_r;
                        end
                    end else begin
                        state_s = ST_GAP;
                    end
                end else begin
                    tmo_en_s = 1'b1;
                    if (tmo_exp_s) begin
                        state_s = ST_ERR;
                    end else begin
                        state_s = ST_ACCESS;
                    end
                end
            end
            ST_GAP:  state_s = ST_ACCESS;
            ST_DONE: state_s = ST_IDLE;
            ST_ERR:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    // State register; bus and status outputs are registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_NONE;
            addr_r      <= 32'd0;
            wdata_r     <= 32'd0;
            idx_r       <= 2'd0;
            ld_buf_r    <= 32'd0;
            rdata_r     <= 32'd0;
            done_n_r    <= 1'b1;
            err_n_r     <= 1'b1;
            bus_oe_n_r  <= 1'b1;
            bus_we_n_r  <= 1'b1;
            bus_addr_r  <= 32'd0;
            bus_wdata_r <= 8'd0;
        end else begin
            state_r    <= state_s;
            op_r       <= op_s;
            addr_r     <= addr_s;
            wdata_r    <= wdata_s;
            idx_r      <= idx_s;
            ld_buf_r   <= ld_buf_s;
            rdata_r    <= rdata_s;
            done_n_r   <= (state_s != ST_DONE);
            err_n_r    <= (state_s != ST_ERR);
            bus_oe_n_r <= !((state_s == ST_ACCESS) && op_is_load(op_s));
            bus_we_n_r <= !((state_s == ST_ACCESS) && !op_is_load(op_s));
            if (state_s == ST_ACCESS) begin
                bus_addr_r  <= {addr_s[31:2], addr_s[1:0] + idx_s};
                bus_wdata_r <= wdata_s[{idx_s, 3'b000} +: 8];
            end else begin
                bus_addr_r  <= bus_addr_r;
                bus_wdata_r <= bus_wdata_r;
            end
        end
    end

    // Stall is released in DONE/ERR so the pipeline advances with the pulse.
    assign busy_s = (state_r == ST_ACCESS) || (state_r == ST_GAP) ||
                    ((state_r == ST_IDLE) && (mem_op != OP_NONE));

    assign stall_n   = !(rst && busy_s);
    assign rdata     = rdata_r;
    assign done_n    = done_n_r;
    assign err_n     = err_n_r;
    assign bus_addr  = bus_addr_r;
    assign bus_wdata = bus_wdata_r;
    assign bus_oe_n  = bus_oe_n_r;
    assign bus_we_n  = bus_we_n_r;

endmodule
